// File: rtl/shared_memory_pkg.sv
// Shared definitions for the shared-memory arbiter: FSM state encoding and
// default address/data widths for the 256-word shared memory.
package shared_memory_pkg;

  localparam int DEFAULT_AW = 8;
  localparam int DEFAULT_DW = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    RSP  = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: the first set request searched upward from (i_last+1)
// with wrap modulo N, returned both one-hot and as an index.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx
);

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    int w_cand;
    o_grant = '0;
    o_idx   = '0;
    w_cand  = 0;
    for (int i = N; i >= 1; i--) begin
      w_cand = int'(i_last) + i;
      if (w_cand >= N) w_cand = w_cand - N;
      if (i_req[w_cand]) begin
        o_grant = N'(1) << w_cand;
        o_idx   = IW'(w_cand);
      end
    end
  end

endmodule

// File: rtl/shared_memory_arbiter.sv
// Round-robin arbiter giving NUM_REQ cores access to one single-port
// synchronous memory; each access is IDLE -> MEM -> RSP (3 cycles).
module shared_memory_arbiter
  import shared_memory_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int AW      = DEFAULT_AW,
  parameter int DW      = DEFAULT_DW
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic [NUM_REQ-1:0]    i_req_valid,
  input  logic [NUM_REQ-1:0]    i_req_we,
  input  logic [NUM_REQ*AW-1:0] i_req_addr,
  input  logic [NUM_REQ*DW-1:0] i_req_wdata,
  output logic [NUM_REQ-1:0]    o_req_ready,
  output logic [NUM_REQ-1:0]    o_rsp_valid,
  output logic [DW-1:0]         o_rsp_rdata,
  output logic                  o_mem_en,
  output logic                  o_mem_we,
  output logic [AW-1:0]         o_mem_addr,
  output logic [DW-1:0]         o_mem_wdata,
  input  logic [DW-1:0]         i_mem_rdata,
  output logic                  o_busy
);

  localparam int IW = $clog2(NUM_REQ);

  state_t               r_state;
  logic [IW-1:0]        r_last;
  logic [IW-1:0]        r_idx;
  logic [AW-1:0]        r_addr;
  logic [DW-1:0]        r_wdata;
  logic                 r_mem_en;
  logic                 r_mem_we;
  logic [NUM_REQ-1:0]   r_rsp_valid;

  logic [NUM_REQ-1:0]   w_grant;
  logic [IW-1:0]        w_grant_idx;
  logic                 w_accept;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr_arbiter (
    .i_req   (i_req_valid),
    .i_last  (r_last),
    .o_grant (w_grant),
    .o_idx   (w_grant_idx)
  );

  assign w_accept    = (r_state == IDLE) && (w_grant != '0);
  // Gated by reset so nothing is offered while the block is held in reset.
  assign o_req_ready = (w_accept && i_reset_n) ? w_grant : '0;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= IDLE;
      r_last      <= IW'(NUM_REQ - 1);
      r_idx       <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_rsp_valid <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_idx    <= w_grant_idx;
            r_last   <= w_grant_idx;
            r_addr   <= i_req_addr[w_grant_idx*AW +: AW];
            r_wdata  <= i_req_wdata[w_grant_idx*DW +: DW];
            r_mem_en <= 1'b1;
            r_mem_we <= i_req_we[w_grant_idx];
            r_state  <= MEM;
          end
        end
        MEM: begin
          r_mem_en    <= 1'b0;
          r_mem_we    <= 1'b0;
          r_rsp_valid <= NUM_REQ'(1) << r_idx;
          r_state     <= RSP;
        end
        RSP: begin
          r_rsp_valid <= '0;
          r_state     <= IDLE;
        end
        default: begin
          r_mem_en    <= 1'b0;
          r_mem_we    <= 1'b0;
          r_rsp_valid <= '0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign o_mem_en    = r_mem_en;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_wdata;
  assign o_rsp_valid = r_rsp_valid;
  // Memory read data arrives one cycle after MEM, i.e. exactly in RSP.
  assign o_rsp_rdata = (r_rsp_valid != '0) ? i_mem_rdata : '0;
  assign o_busy      = (r_state != IDLE);

endmodule

// File: tb/tb_shared_memory_arbiter.sv
// Scoreboard bench for shared_memory_arbiter: directed requests push expected
// grants/responses; a negedge monitor pops and compares.
module tb_shared_memory_arbiter;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    i_req_valid;
  logic [N-1:0]    i_req_we;
  logic [N*AW-1:0] i_req_addr;
  logic [N*DW-1:0] i_req_wdata;
  logic [N-1:0]    o_req_ready;
  logic [N-1:0]    o_rsp_valid;
  logic [DW-1:0]   o_rsp_rdata;
  logic            o_mem_en;
  logic            o_mem_we;
  logic [AW-1:0]   o_mem_addr;
  logic [DW-1:0]   o_mem_wdata;
  logic [DW-1:0]   mem_rdata;
  logic            o_busy;

  int tot = 0;
  int bad = 0;
  int cyc = 0;

  int              exp_grant_q[$];
  int              exp_ridx_q[$];
  logic [DW-1:0]   exp_rdata_q[$];
  int              acc_cyc_q[$];
  logic [AW+DW:0]  pend_q[N][$];

  logic [DW-1:0]   mem [256];

  shared_memory_arbiter #(
    .NUM_REQ (N),
    .AW      (AW),
    .DW      (DW)
  ) dut (
    .i_clk       (clk),
    .i_reset_n   (rst_n),
    .i_req_valid (i_req_valid),
    .i_req_we    (i_req_we),
    .i_req_addr  (i_req_addr),
    .i_req_wdata (i_req_wdata),
    .o_req_ready (o_req_ready),
    .o_rsp_valid (o_rsp_valid),
    .o_rsp_rdata (o_rsp_rdata),
    .o_mem_en    (o_mem_en),
    .o_mem_we    (o_mem_we),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .i_mem_rdata (mem_rdata),
    .o_busy      (o_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous read-before-write memory; reloaded with mem[i]=i+1 (i<8) on reset.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= (i < 8) ? DW'(i + 1) : '0;
      mem_rdata <= '0;
    end else if (o_mem_en) begin
      mem_rdata <= mem[o_mem_addr];
      if (o_mem_we) mem[o_mem_addr] <= o_mem_wdata;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tot++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_evt(input string name);
    tot++;
    bad++;
    $display("FAIL %s: got event want none (cycle %0d)", name, cyc);
  endtask

  function automatic int first_bit(input logic [N-1:0] v);
    int r = -1;
    for (int i = N - 1; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  // Monitor: grants, responses, latency and reset-state checks.
  always @(negedge clk) begin
    logic [N-1:0] taken;
    if (!rst_n) begin
      chk("rst_ready", 64'(o_req_ready), 64'(0));
      chk("rst_rsp_valid", 64'(o_rsp_valid), 64'(0));
      chk("rst_mem_en", 64'(o_mem_en), 64'(0));
      chk("rst_busy", 64'(o_busy), 64'(0));
      acc_cyc_q.delete();
    end else begin
      chk("ready_onehot0", 64'($onehot0(o_req_ready)), 64'(1));
      taken = o_req_ready & i_req_valid;
      if (taken != '0) begin
        if (exp_grant_q.size() == 0) fail_evt("grant_extra");
        else chk("grant_idx", 64'(first_bit(taken)), 64'(exp_grant_q.pop_front()));
        acc_cyc_q.push_back(cyc);
      end
      if (o_rsp_valid != '0) begin
        chk("rsp_onehot", 64'($onehot(o_rsp_valid)), 64'(1));
        if (exp_ridx_q.size() == 0) fail_evt("rsp_extra");
        else begin
          chk("rsp_idx", 64'(first_bit(o_rsp_valid)), 64'(exp_ridx_q.pop_front()));
          chk("rsp_rdata", 64'(o_rsp_rdata), 64'(exp_rdata_q.pop_front()));
        end
        if (acc_cyc_q.size() == 0) fail_evt("rsp_without_accept");
        else chk("rsp_latency", 64'(cyc - acc_cyc_q.pop_front()), 64'(2));
      end
      if (o_mem_en) chk("mem_en_not_idle", 64'(o_busy), 64'(1));
    end
  end

  task automatic expect_rsp(input int g, input logic [DW-1:0] d);
    exp_grant_q.push_back(g);
    exp_ridx_q.push_back(g);
    exp_rdata_q.push_back(d);
  endtask

  task automatic queue_req(input int k, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    pend_q[k].push_back({we, a, d});
  endtask

  function automatic bit any_pending();
    bit r = 1'b0;
    for (int k = 0; k < N; k++) if (pend_q[k].size() > 0) r = 1'b1;
    return r;
  endfunction

  task automatic load_reqs();
    logic [AW+DW:0] e;
    for (int k = 0; k < N; k++) begin
      if (!i_req_valid[k] && pend_q[k].size() > 0) begin
        e = pend_q[k].pop_front();
        i_req_we[k]               = e[AW+DW];
        i_req_addr[k*AW +: AW]    = e[DW +: AW];
        i_req_wdata[k*DW +: DW]   = e[DW-1:0];
        i_req_valid[k]            = 1'b1;
      end
    end
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_ridx_q.size() > 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_ridx_q.size() > 0) fail_evt("drain_timeout");
    @(posedge clk);
    #1;
  endtask

  // Hold each requester valid until accepted, then present its next request.
  task automatic run_queued(input int budget);
    int n = 0;
    logic [N-1:0] taken;
    load_reqs();
    while ((any_pending() || i_req_valid != '0) && n < budget) begin
      @(negedge clk);
      taken = o_req_ready & i_req_valid;
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) if (taken[k]) i_req_valid[k] = 1'b0;
      load_reqs();
      n++;
    end
    if (n >= budget) fail_evt("drive_timeout");
    wait_drain(budget);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    rst_n       = 1'b0;
    i_req_valid = '1;
    i_req_we    = '0;
    i_req_addr  = '0;
    i_req_wdata = '0;
    repeat (3) @(negedge clk);
    i_req_valid = '0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single read: req0 addr 3 -> ready same cycle, mem at T+1, rdata 4 at T+2.
    expect_rsp(0, 32'd4);
    i_req_addr[0 +: AW] = 8'd3;
    i_req_valid[0] = 1'b1;
    @(negedge clk);
    chk("t1_ready", 64'(o_req_ready), 64'(4'b0001));
    @(posedge clk);
    #1;
    i_req_valid[0] = 1'b0;
    @(negedge clk);
    chk("t1_mem_en", 64'(o_mem_en), 64'(1));
    chk("t1_mem_we", 64'(o_mem_we), 64'(0));
    chk("t1_mem_addr", 64'(o_mem_addr), 64'(3));
    chk("t1_busy", 64'(o_busy), 64'(1));
    wait_drain(10);

    // All four read addr 0..3 together from reset: order 0,1,2,3.
    do_reset();
    for (int k = 0; k < N; k++) begin
      expect_rsp(k, DW'(k + 1));
      queue_req(k, 1'b0, AW'(k), '0);
    end
    run_queued(60);

    // req2 write then read of addr 20.
    expect_rsp(2, 32'd0);
    expect_rsp(2, 32'hDEADBEEF);
    queue_req(2, 1'b1, 8'd20, 32'hDEADBEEF);
    queue_req(2, 1'b0, 8'd20, '0);
    run_queued(40);

    // req0 and req1 continuously valid: strict alternation starting at 0.
    for (int j = 0; j < 4; j++) begin
      expect_rsp(0, DW'(j + 5));
      expect_rsp(1, DW'(j + 1));
      queue_req(0, 1'b0, AW'(4 + j), '0);
      queue_req(1, 1'b0, AW'(j), '0);
    end
    run_queued(80);

    // Reset during the MEM cycle of a req1 read abandons it.
    exp_grant_q.push_back(1);
    i_req_addr[1*AW +: AW] = 8'd2;
    i_req_we[1]    = 1'b0;
    i_req_valid[1] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_req_ready[1] && n < 10);
    if (!o_req_ready[1]) fail_evt("t5_accept_timeout");
    @(posedge clk);
    #1;
    i_req_valid[1] = 1'b0;
    chk("t5_mem_en_pre", 64'(o_mem_en), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("t5_mem_en_rst", 64'(o_mem_en), 64'(0));
    chk("t5_busy_rst", 64'(o_busy), 64'(0));
    chk("t5_rsp_valid_rst", 64'(o_rsp_valid), 64'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    expect_rsp(0, 32'd2);
    expect_rsp(3, 32'd6);
    queue_req(0, 1'b0, 8'd1, '0);
    queue_req(3, 1'b0, 8'd5, '0);
    run_queued(40);

    repeat (4) @(negedge clk);
    chk("grant_q_empty", 64'(exp_grant_q.size()), 64'(0));
    chk("rsp_q_empty", 64'(exp_ridx_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/shared_memory_arbiter.md
SHARED_MEMORY_ARBITER -- requirements
Module: shared_memory_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesting cores (2..8).
REQ-002 Parameter AW, default 8, word-address width (256-word shared memory).
REQ-003 Parameter DW, default 32, data width.
REQ-004 i_clk  input  1  single clock, all logic on rising edge.
REQ-005 i_reset_n  input  1  reset, asynchronous assert, active-low.
REQ-006 i_req_valid  input  NUM_REQ  per-requester access request.
REQ-007 i_req_we  input  NUM_REQ  per-requester write enable.
REQ-008 i_req_addr  input  NUM_REQ*AW  packed addresses, requester k at bits [k*AW +: AW].
REQ-009 i_req_wdata  input  NUM_REQ*DW  packed write data, requester k at [k*DW +: DW].
REQ-010 o_req_ready  output  NUM_REQ  one-hot accept; transfer when valid&ready.
REQ-011 o_rsp_valid  output  NUM_REQ  one-hot completion strobe, one cycle.
REQ-012 o_rsp_rdata  output  DW  read data, valid while any o_rsp_valid bit is set.
REQ-013 o_mem_en, o_mem_we  output  1 each  memory access strobe and write enable.
REQ-014 o_mem_addr  output  AW; o_mem_wdata  output  DW  memory address and write data.
REQ-015 i_mem_rdata  input  DW  synchronous memory read data, one-cycle latency, read-before-write.
REQ-016 o_busy  output  1  high in any state other than IDLE.

Function
REQ-017 FSM states IDLE, MEM, RSP; IDLE->MEM on accept, MEM->RSP unconditionally, RSP->IDLE unconditionally.
REQ-018 In IDLE, o_req_ready SHALL be the combinational one-hot grant of the first valid requester searched from (last_grant+1) mod NUM_REQ upward with wrap; all-zero when no valid or not IDLE.
REQ-019 On accept (edge T), latch grant index, addr, wdata, we; set last_grant to the granted index.
REQ-020 In MEM (cycle T+1), o_mem_en=1, o_mem_we=latched we, o_mem_addr/o_mem_wdata=latched values, all registered; otherwise o_mem_en=0, o_mem_we=0.
REQ-021 In RSP (cycle T+2), o_rsp_valid has exactly the granted bit set; o_rsp_rdata=i_mem_rdata; otherwise o_rsp_valid=0, o_rsp_rdata=0.
REQ-022 Writes SHALL also produce o_rsp_valid (ack); o_rsp_rdata then carries the pre-write word.
REQ-023 Latency request-accept to response is exactly 2 cycles; peak throughput one access per 3 cycles.
REQ-024 Requesters hold valid/we/addr/wdata until accepted; dropping valid before accept is legal and has no effect.
REQ-025 A requester asserting valid in MEM/RSP is not accepted until the next IDLE cycle, then arbitrated normally.
REQ-026 Single valid requester is granted regardless of pointer; no requester starves: each valid requester is granted within NUM_REQ accepts.
REQ-027 Address is used as given, no bounds check; index wrap in the arbiter search is modulo NUM_REQ.

Reset
REQ-028 While i_reset_n=0: state IDLE, last_grant=NUM_REQ-1 (requester 0 has first priority), all outputs 0, latched fields 0.
REQ-029 Reset asserted in MEM or RSP abandons the access: no o_rsp_valid is produced; a write in flight may or may not have reached memory.
REQ-030 Release from reset SHALL be synchronous to i_clk.

Structure
REQ-031 State encoding enum (IDLE, MEM, RSP) and default AW/DW constants live in shared package shared_memory_pkg.
REQ-032 Round-robin grant logic is one sub-module rr_arbiter (inputs request vector and last index, outputs one-hot grant and index).
REQ-033 Block connects directly to shared_memory ports (addr, data_in, we, data_out); o_mem_en gates we at integration.

Verification
REQ-034 Memory pre-loaded mem[i]=i+1; req0 read addr 3 -> o_req_ready[0] same cycle, o_mem_en at T+1, o_rsp_valid=4'b0001 with rdata 4 at T+2.
REQ-035 All four requesters read addr 0..3 simultaneously from reset -> grants in order 0,1,2,3, rdata 1,2,3,4, responses 3 cycles apart.
REQ-036 req2 writes 0xDEADBEEF to addr 20 then reads addr 20 -> write ack rdata 0, read rdata 0xDEADBEEF.
REQ-037 req0 and req1 continuously valid for 8 accesses -> strict alternation 0,1,0,1..., never two consecutive grants to one requester.
REQ-038 Reset asserted at MEM cycle of req1 read -> o_rsp_valid stays 0, outputs 0 immediately, next access granted to req0 first.
REQ-039 Formal: o_req_ready and o_rsp_valid each $onehot0; o_rsp_valid only two cycles after matching accept; o_mem_en never in IDLE.
